i2c_cmd_arbiter: RTL and testbench
==================================

Name: i2c_cmd_arbiter

Overview:
- Shares one i2c_master command/receive FIFO pair between NREQ transaction-level requesters, for example apb_eeprom and a sensor poller.
- Grants the bus one whole I2C transaction at a time, in round-robin order.
- Forwards only the owner's command pushes and receive pops.
- Releases ownership only after the transaction has completed and the receive FIFO is drained. A timeout guarantees forward progress.

Parameters:
- NREQ, 2: number of requesters (2..8).
- TIMEOUT_CYC, 100000: clk cycles allowed from stop-command push to release. 0 disables the timeout.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NREQ  level request per requester; held until req_txn_done.
- req_cmd_push  in  NREQ  command push per requester.
- req_cmd_din  in  NREQ*10  commands; slice i is [10*i+9:10*i], format {start, stop, byte[7:0]}.
- req_cmd_full  out  NREQ  backpressure per requester.
- req_rxd_pop  in  NREQ  receive pop per requester.
- req_rxd_dout  out  8  i2c_rxd_fifo_dout broadcast to all requesters.
- req_rxd_empty  out  NREQ  receive-empty per requester.
- grant  out  NREQ  one-hot current owner.
- req_txn_done  out  NREQ  1-cycle release pulse.
- req_err  out  NREQ  error status of the last transaction.
- i2c_cmd_fifo_push  out  1  to i2c_master.
- i2c_cmd_fifo_din  out  10  to i2c_master.
- i2c_cmd_fifo_full  in  1  from i2c_master.
- i2c_rxd_fifo_pop  out  1  to i2c_master.
- i2c_rxd_fifo_dout  in  8  from i2c_master.
- i2c_rxd_fifo_empty  in  1  from i2c_master.
- i2c_txd_cmp  in  1  transaction-complete pulse from i2c_master.
- i2c_rxd_cmp  in  1  transaction-complete pulse from i2c_master.
- i2c_addr_noack_err  in  1  NACK pulse from i2c_master.
- i2c_data_noack_err  in  1  NACK pulse from i2c_master.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; grant=0; req_txn_done=0; req_err=0.
  - Round-robin pointer=0; timeout counter=0; sticky error=0.
- States:
  - IDLE: if any req, select the first requesting index at or after the pointer, wrapping modulo NREQ. Register the one-hot grant, go to OWN next cycle, and set pointer=(winner+1) mod NREQ. Grant is never asserted in IDLE.
  - OWN: the owner's push and din are forwarded combinationally; i2c_cmd_fifo_push = req_cmd_push[owner] & ~i2c_cmd_fifo_full.
    - Push acceptance: a push is accepted only when the FIFO is not full.
    - Transition: an accepted command with stop=1 moves to WAIT_CMP and clears the timeout counter.
    - Ignored inputs: non-owner pushes and pops are dropped; cmp pulses are ignored.
  - WAIT_CMP: the counter increments each cycle.
    - i2c_txd_cmp or i2c_rxd_cmp moves to DRAIN.
    - Counter reaching TIMEOUT_CYC sets the sticky error and moves to FLUSH.
  - DRAIN: if i2c_rxd_fifo_empty, move to RELEASE. Otherwise the owner pops; the counter keeps running and timeout moves to FLUSH.
  - FLUSH: the arbiter drives i2c_rxd_fifo_pop=~i2c_rxd_fifo_empty, ignores owner pops, and moves to RELEASE when empty.
  - RELEASE (1 cycle):
    - Pulse req_txn_done[owner].
    - Load req_err[owner] with the sticky error; other req_err bits are unchanged.
    - Clear grant, the sticky error and the counter; go to IDLE.
    - The earliest re-grant is 2 cycles after the done pulse.
- Sticky error: set by i2c_addr_noack_err or i2c_data_noack_err in OWN, WAIT_CMP or DRAIN. A NACK does not by itself change state; i2c_master still reports cmp.
- Outputs per requester:
  - req_cmd_full[i] = grant[i] & state==OWN ? i2c_cmd_fifo_full : 1.
  - req_rxd_empty[i] = grant[i] & state∈{OWN, WAIT_CMP, DRAIN} ? i2c_rxd_fifo_empty : 1.
  - i2c_rxd_fifo_pop = req_rxd_pop[owner] & ~i2c_rxd_fifo_empty, except in FLUSH.
- Simultaneous events:
  - A stop push and a cmp pulse in the same cycle: the cmp is ignored as stale.
  - A NACK and a cmp in the same cycle: both take effect.
  - Timeout on the same cycle as cmp: cmp wins.
- A requester dropping req while owning has no effect; ownership ends only via RELEASE.
- With TIMEOUT_CYC=0 the counter never triggers.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. The i2c_master is reset by the same system reset.

Test Plan:
- Single write: req[0]=1, push 7 commands {1,0,0xA0},{0,0,0x00},{0,0,0x10},{0,0,0x11},{0,0,0x22},{0,0,0x33},{0,1,0x44}, then txd_cmp.
  - Expect grant=01 1 cycle after req, 7 forwarded pushes with identical din, req_txn_done[0] pulse, req_err[0]=0.
- Round-robin: req=11 held continuously with both requesters completing transactions.
  - Expect grant order 01, 10, 01, 10.
  - Expect req_cmd_full[1]=1 and requester 1's pushes never forwarded while grant=01.
- Read: owner 1 pushes 5 commands ending in stop; model returns 0xDE, 0xAD, 0xBE, 0xEF then rxd_cmp.
  - Owner pops 4 bytes in order; release only after empty.
- NACK: addr_noack_err pulse during WAIT_CMP, then txd_cmp.
  - Expect req_txn_done[0] with req_err[0]=1; next clean transaction clears req_err[0] to 0.
- Timeout: TIMEOUT_CYC=16, no cmp after stop, 2 bytes left in the receive FIFO.
  - Expect FLUSH pops 2 bytes, done pulse 16+2+1 cycles after the stop push, req_err=1, FIFO empty.
- Reset mid-op: assert rst in WAIT_CMP between clock edges.
  - Expect grant=0 and state IDLE immediately, without waiting for a clk edge.
  - After release, a fresh req is granted requester 0 first.

Source files
------------

// File: rtl/i2c_cmd_arbiter_if.sv
// i2c_master side of the command arbiter: command FIFO, receive FIFO and
// the completion/NACK status pulses.
interface i2c_cmd_arbiter_if;
    logic       i2c_cmd_fifo_push;
    logic [9:0] i2c_cmd_fifo_din;
    logic       i2c_cmd_fifo_full;
    logic       i2c_rxd_fifo_pop;
    logic [7:0] i2c_rxd_fifo_dout;
    logic       i2c_rxd_fifo_empty;
    logic       i2c_txd_cmp;
    logic       i2c_rxd_cmp;
    logic       i2c_addr_noack_err;
    logic       i2c_data_noack_err;

    modport master (
        output i2c_cmd_fifo_push, i2c_cmd_fifo_din, i2c_rxd_fifo_pop,
        input  i2c_cmd_fifo_full, i2c_rxd_fifo_dout, i2c_rxd_fifo_empty,
        input  i2c_txd_cmp, i2c_rxd_cmp, i2c_addr_noack_err, i2c_data_noack_err
    );

    modport slave (
        input  i2c_cmd_fifo_push, i2c_cmd_fifo_din, i2c_rxd_fifo_pop,
        output i2c_cmd_fifo_full, i2c_rxd_fifo_dout, i2c_rxd_fifo_empty,
        output i2c_txd_cmp, i2c_rxd_cmp, i2c_addr_noack_err, i2c_data_noack_err
    );
endinterface

// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one i2c_master FIFO pair between NREQ requesters,
// one whole transaction at a time, with a completion timeout and receive flush.
module i2c_cmd_arbiter #(
    parameter int NREQ        = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_cmd_push,
    input  logic [NREQ*10-1:0]   req_cmd_din,
    output logic [NREQ-1:0]      req_cmd_full,
    input  logic [NREQ-1:0]      req_rxd_pop,
    output logic [7:0]           req_rxd_dout,
    output logic [NREQ-1:0]      req_rxd_empty,
    output logic [NREQ-1:0]      grant,
    output logic [NREQ-1:0]      req_txn_done,
    output logic [NREQ-1:0]      req_err,
    i2c_cmd_arbiter_if.master    i2c
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYC > 0);
    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYC);

    typedef enum logic [2:0] {
        ST_IDLE, ST_OWN, ST_WAIT_CMP, ST_DRAIN, ST_FLUSH, ST_RELEASE
    } state_t;

    state_t            state_r, state_s;
    logic [NREQ-1:0]   grant_r, grant_s;
    logic [NREQ-1:0]   done_r, done_s;
    logic [NREQ-1:0]   req_err_r, req_err_s;
    logic [IDX_W-1:0]  owner_r, owner_s;
    logic [IDX_W-1:0]  ptr_r, ptr_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic              win_found_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s, cnt_inc_s;
    logic              err_r, err_s;
    logic              in_txn_s, nack_s, cmp_s, timeout_hit_s, stop_acc_s;
    logic [9:0]        owner_din_s;

    // Index offset from a base, wrapped modulo NREQ.
    function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        return (sum >= NREQ) ? IDX_W'(sum - NREQ) : IDX_W'(sum);
    endfunction

    assign in_txn_s      = (state_r == ST_OWN) || (state_r == ST_WAIT_CMP) || (state_r == ST_DRAIN);
    assign nack_s        = i2c.i2c_addr_noack_err | i2c.i2c_data_noack_err;
    assign cmp_s         = i2c.i2c_txd_cmp | i2c.i2c_rxd_cmp;
    assign cnt_inc_s     = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign timeout_hit_s = TIMEOUT_EN && (cnt_inc_s == TIMEOUT_VAL);
    assign owner_din_s   = req_cmd_din[int'(owner_r)*10 +: 10];

    assign i2c.i2c_cmd_fifo_push = (state_r == ST_OWN) & req_cmd_push[owner_r] & ~i2c.i2c_cmd_fifo_full;
    assign i2c.i2c_cmd_fifo_din  = owner_din_s;
    assign i2c.i2c_rxd_fifo_pop  = (state_r == ST_FLUSH) ? ~i2c.i2c_rxd_fifo_empty
                                 : (in_txn_s & req_rxd_pop[owner_r] & ~i2c.i2c_rxd_fifo_empty);
    assign stop_acc_s   = i2c.i2c_cmd_fifo_push & owner_din_s[8];
    assign req_rxd_dout = i2c.i2c_rxd_fifo_dout;
    assign grant        = grant_r;
    assign req_txn_done = done_r;
    assign req_err      = req_err_r;

    // Per-requester backpressure and receive-empty views; non-owners see a blocked FIFO pair.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_cmd_full[i]  = (grant_r[i] && (state_r == ST_OWN)) ? i2c.i2c_cmd_fifo_full : 1'b1;
            req_rxd_empty[i] = (grant_r[i] && in_txn_s) ? i2c.i2c_rxd_fifo_empty : 1'b1;
        end
    end

    // Round-robin pick: first requester at or after the pointer.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!win_found_s && req[rr_idx(ptr_r, i)]) begin
                win_found_s = 1'b1;
                win_idx_s   = rr_idx(ptr_r, i);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Next-state and next-register logic for the ownership FSM.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        owner_s   = owner_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        err_s     = err_r | (nack_s & in_txn_s);
        done_s    = '0;
        req_err_s = req_err_r;
        case (state_r)
            ST_IDLE: begin
                if (win_found_s) begin
                    state_s = ST_OWN;
                    grant_s = {{(NREQ-1){1'b0}}, 1'b1} << win_idx_s;
                    owner_s = win_idx_s;
                    ptr_s   = rr_idx(win_idx_s, 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OWN: begin
                // cmp pulses seen here belong to an earlier transaction
                if (stop_acc_s) begin
                    state_s = ST_WAIT_CMP;
                    cnt_s   = '0;
                end else begin
                    state_s = ST_OWN;
                end
            end
            ST_WAIT_CMP: begin
                cnt_s = cnt_inc_s;
                if (cmp_s) begin
                    state_s = ST_DRAIN;
                end else if (timeout_hit_s) begin
                    err_s   = 1'b1;
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_WAIT_CMP;
                end
            end
            ST_DRAIN: begin
                cnt_s = cnt_inc_s;
                if (i2c.i2c_rxd_fifo_empty) begin
                    state_s = ST_RELEASE;
                end else if (timeout_hit_s) begin
                    err_s   = 1'b1;
                    state_s = ST_FLUSH;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                if (i2c.i2c_rxd_fifo_empty) begin
                    state_s = ST_RELEASE;
                end else begin
                    state_s = ST_FLUSH;
                end
            end
            ST_RELEASE: begin
                state_s = ST_IDLE;
                grant_s = '0;
                err_s   = 1'b0;
                cnt_s   = '0;
            end
            default: begin
                state_s = ST_IDLE;
                grant_s = '0;
                err_s   = 1'b0;
                cnt_s   = '0;
            end
        endcase
        // Done pulse and error status are registered so they line up with the RELEASE cycle.
        if (state_s == ST_RELEASE) begin
            done_s    = grant_r;
            req_err_s = (req_err_r & ~grant_r) | (grant_r & {NREQ{err_s}});
        end else begin
            done_s    = '0;
        end
    end

    // State and status registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            grant_r   <= '0;
            owner_r   <= '0;
            ptr_r     <= '0;
            cnt_r     <= '0;
            err_r     <= 1'b0;
            done_r    <= '0;
            req_err_r <= '0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            owner_r   <= owner_s;
            ptr_r     <= ptr_s;
            cnt_r     <= cnt_s;
            err_r     <= err_s;
            done_r    <= done_s;
            req_err_r <= req_err_s;
        end
    end
endmodule

// File: tb/tb_i2c_cmd_arbiter.sv
// Directed bench for i2c_cmd_arbiter with a small i2c_master FIFO model.
module tb_i2c_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [1:0]  req_cmd_push = 2'b00;
    logic [19:0] req_cmd_din = 20'h0;
    logic [1:0]  req_rxd_pop = 2'b00;
    logic [1:0]  req_cmd_full, req_rxd_empty, grant, req_txn_done, req_err;
    logic [7:0]  req_rxd_dout;

    int total = 0;
    int bad   = 0;

    logic [9:0] cmd_log [64];
    int         cmd_cnt = 0;
    logic [7:0] rx_mem [16];
    int         rx_wr = 0;
    int         rx_rd = 0;

    typedef struct {
        logic [1:0] push;
        logic [9:0] din0;
        logic [9:0] din1;
        logic       full;
        logic       exp_push;
        logic [1:0] exp_cmd_full;
    } vec_t;
    vec_t       tbl [9];
    logic [9:0] exp_cmds [7];

    i2c_cmd_arbiter_if bus ();

    i2c_cmd_arbiter #(.NREQ(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_cmd_push(req_cmd_push), .req_cmd_din(req_cmd_din), .req_cmd_full(req_cmd_full),
        .req_rxd_pop(req_rxd_pop), .req_rxd_dout(req_rxd_dout), .req_rxd_empty(req_rxd_empty),
        .grant(grant), .req_txn_done(req_txn_done), .req_err(req_err),
        .i2c(bus)
    );

    always #5 clk = ~clk;

    assign bus.i2c_rxd_fifo_empty = (rx_wr == rx_rd);
    assign bus.i2c_rxd_fifo_dout  = rx_mem[rx_rd[3:0]];

    // i2c_master FIFO model: log accepted commands, consume popped bytes.
    always @(posedge clk) begin
        if (bus.i2c_cmd_fifo_push) begin
            cmd_log[cmd_cnt[5:0]] <= bus.i2c_cmd_fifo_din;
            cmd_cnt <= cmd_cnt + 1;
        end
        if (bus.i2c_rxd_fifo_pop) begin
            rx_rd <= rx_rd + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rx_load(input logic [7:0] b);
        rx_mem[rx_wr[3:0]] = b;
        rx_wr = rx_wr + 1;
    endtask

    task automatic push_cmd(input int idx, input logic [9:0] din);
        step();
        req_cmd_push[idx] = 1'b1;
        req_cmd_din[idx*10 +: 10] = din;
        step();
        req_cmd_push[idx] = 1'b0;
    endtask

    task automatic pulse_cmp(input bit rxd);
        step();
        if (rxd) bus.i2c_rxd_cmp = 1'b1; else bus.i2c_txd_cmp = 1'b1;
        step();
        bus.i2c_rxd_cmp = 1'b0;
        bus.i2c_txd_cmp = 1'b0;
    endtask

    task automatic wait_grant(output int m);
        bit seen0;
        seen0 = (grant == 2'b00);
        m = 0;
        while (m < 32) begin
            @(negedge clk);
            m++;
            if (grant == 2'b00) seen0 = 1'b1;
            else if (seen0) break;
        end
    endtask

    task automatic wait_done(input logic [1:0] exp, input logic [1:0] exp_err,
                             input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (req_txn_done == 2'b00 && n < 64);
        chk({nm, "_done"}, req_txn_done, exp);
        chk({nm, "_err"}, req_err, exp_err);
    endtask

    task automatic rr_txn(input int k);
        int m, n, c0, idx, oth;
        logic [1:0] exp;
        logic [9:0] own;
        idx = k % 2;
        oth = 1 - idx;
        exp = (idx == 0) ? 2'b01 : 2'b10;
        own = 10'h300 + 10'(k);
        wait_grant(m);
        chk("rr_grant", grant, exp);
        if (k > 0) chk("rr_regrant_gap", m, 2);
        c0 = cmd_cnt;
        step();
        req_cmd_push = 2'b11;
        req_cmd_din[idx*10 +: 10] = own;
        req_cmd_din[oth*10 +: 10] = 10'h0FF;
        @(negedge clk);
        chk("rr_other_full", req_cmd_full[oth], 1);
        chk("rr_fwd_din", bus.i2c_cmd_fifo_din, own);
        step();
        req_cmd_push = 2'b00;
        chk("rr_one_push", cmd_cnt - c0, 1);
        chk("rr_logged", cmd_log[c0[5:0]], own);
        pulse_cmp(1'b0);
        wait_done(exp, 2'b00, "rr", n);
    endtask

    initial begin
        int n, m, stray;
        logic [7:0] rd_bytes [4];
        tbl[0] = '{2'b11, 10'h2A0, 10'h3FF, 1'b0, 1'b1, 2'b10};
        tbl[1] = '{2'b01, 10'h000, 10'h000, 1'b1, 1'b0, 2'b11};
        tbl[2] = '{2'b01, 10'h000, 10'h000, 1'b0, 1'b1, 2'b10};
        tbl[3] = '{2'b10, 10'h010, 10'h155, 1'b0, 1'b0, 2'b10};
        tbl[4] = '{2'b01, 10'h010, 10'h000, 1'b0, 1'b1, 2'b10};
        tbl[5] = '{2'b01, 10'h011, 10'h000, 1'b0, 1'b1, 2'b10};
        tbl[6] = '{2'b01, 10'h022, 10'h000, 1'b0, 1'b1, 2'b10};
        tbl[7] = '{2'b01, 10'h033, 10'h000, 1'b0, 1'b1, 2'b10};
        tbl[8] = '{2'b01, 10'h144, 10'h000, 1'b0, 1'b1, 2'b10};
        exp_cmds = '{10'h2A0, 10'h000, 10'h010, 10'h011, 10'h022, 10'h033, 10'h144};
        rd_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        bus.i2c_cmd_fifo_full  = 1'b0;
        bus.i2c_txd_cmp        = 1'b0;
        bus.i2c_rxd_cmp        = 1'b0;
        bus.i2c_addr_noack_err = 1'b0;
        bus.i2c_data_noack_err = 1'b0;

        // reset state
        #20;
        @(negedge clk);
        chk("rst_grant", grant, 2'b00);
        chk("rst_done", req_txn_done, 2'b00);
        chk("rst_err", req_err, 2'b00);
        chk("rst_cmd_full", req_cmd_full, 2'b11);
        chk("rst_rxd_empty", req_rxd_empty, 2'b11);
        chk("rst_push", bus.i2c_cmd_fifo_push, 1'b0);
        #3 rst = 1'b1;

        // single write, table driven
        step();
        req = 2'b01;
        @(negedge clk);
        chk("sw_no_grant_idle", grant, 2'b00);
        @(negedge clk);
        chk("sw_grant", grant, 2'b01);
        for (int i = 0; i < 9; i++) begin
            step();
            req_cmd_push = tbl[i].push;
            req_cmd_din  = {tbl[i].din1, tbl[i].din0};
            bus.i2c_cmd_fifo_full = tbl[i].full;
            @(negedge clk);
            chk($sformatf("sw_push_%0d", i), bus.i2c_cmd_fifo_push, tbl[i].exp_push);
            chk($sformatf("sw_din_%0d", i), bus.i2c_cmd_fifo_din, tbl[i].din0);
            chk($sformatf("sw_full_%0d", i), req_cmd_full, tbl[i].exp_cmd_full);
        end
        step();
        req_cmd_push = 2'b00;
        bus.i2c_cmd_fifo_full = 1'b0;
        chk("sw_cmd_count", cmd_cnt, 7);
        for (int i = 0; i < 7; i++) chk($sformatf("sw_cmd_%0d", i), cmd_log[i], exp_cmds[i]);
        @(negedge clk);
        chk("sw_full_after_stop", req_cmd_full, 2'b11);
        pulse_cmp(1'b0);
        wait_done(2'b01, 2'b00, "sw", n);
        req = 2'b00;
        @(negedge clk);
        chk("sw_done_one_cycle", req_txn_done, 2'b00);
        chk("sw_grant_cleared", grant, 2'b00);

        // read by requester 1
        step();
        req = 2'b10;
        wait_grant(m);
        chk("rd_grant", grant, 2'b10);
        push_cmd(1, 10'h2A0);
        push_cmd(1, 10'h000);
        push_cmd(1, 10'h2A1);
        push_cmd(1, 10'h000);
        push_cmd(1, 10'h100);
        for (int i = 0; i < 4; i++) rx_load(rd_bytes[i]);
        pulse_cmp(1'b1);
        req_rxd_pop = 2'b10;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("rd_byte_%0d", i), req_rxd_dout, rd_bytes[i]);
            chk($sformatf("rd_empty_%0d", i), req_rxd_empty, 2'b01);
            chk($sformatf("rd_no_early_done_%0d", i), req_txn_done, 2'b00);
            step();
        end
        req_rxd_pop = 2'b00;
        wait_done(2'b10, 2'b00, "rd", n);
        chk("rd_fifo_empty", bus.i2c_rxd_fifo_empty, 1'b1);
        req = 2'b00;

        // NACK during WAIT_CMP, then a clean transaction with a stale cmp at the stop push
        step();
        req = 2'b01;
        wait_grant(m);
        chk("nk_grant", grant, 2'b01);
        push_cmd(0, 10'h3A0);
        step();
        bus.i2c_addr_noack_err = 1'b1;
        step();
        bus.i2c_addr_noack_err = 1'b0;
        pulse_cmp(1'b0);
        wait_done(2'b01, 2'b01, "nk", n);
        wait_grant(m);
        chk("cl_grant", grant, 2'b01);
        step();
        req_cmd_push[0] = 1'b1;
        req_cmd_din[9:0] = 10'h3A5;
        bus.i2c_txd_cmp = 1'b1;
        step();
        req_cmd_push[0] = 1'b0;
        bus.i2c_txd_cmp = 1'b0;
        stray = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (req_txn_done != 2'b00) stray++;
        end
        chk("cl_stale_cmp_ignored", stray, 0);
        pulse_cmp(1'b0);
        wait_done(2'b01, 2'b00, "cl", n);
        req = 2'b00;

        // timeout with 2 bytes left in the receive FIFO
        step();
        req = 2'b01;
        wait_grant(m);
        chk("to_grant", grant, 2'b01);
        step();
        req_cmd_push[0] = 1'b1;
        req_cmd_din[9:0] = 10'h3C0;
        rx_load(8'h11);
        rx_load(8'h22);
        step();
        req_cmd_push[0] = 1'b0;
        wait_done(2'b01, 2'b01, "to", n);
        chk("to_latency", n - 1, 16 + 2 + 1);
        chk("to_flushed", bus.i2c_rxd_fifo_empty, 1'b1);
        req = 2'b00;

        // asynchronous reset in WAIT_CMP
        step();
        req = 2'b01;
        wait_grant(m);
        chk("rs_grant", grant, 2'b01);
        push_cmd(0, 10'h3C1);
        #3 rst = 1'b0;
        #1;
        chk("rs_grant_async", grant, 2'b00);
        chk("rs_err_async", req_err, 2'b00);
        chk("rs_done_async", req_txn_done, 2'b00);
        chk("rs_cmd_full_async", req_cmd_full, 2'b11);
        req = 2'b00;
        #22 rst = 1'b1;

        // round robin with both requesters held
        step();
        req = 2'b11;
        for (int k = 0; k < 4; k++) rr_txn(k);
        req = 2'b00;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
